// File: rtl/fpu_op_sequencer.sv
// Issues one F-extension op at a time: latches the FPU_Control select, times the op class
// latency, captures the muxed result and holds it under a valid/ready response handshake.
module fpu_op_sequencer #(
  parameter int ADD_LAT  = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 8,
  parameter int MISC_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req_Valid,
  input  logic [3:0]  Req_Op,
  output logic        Req_Ready,
  output logic [3:0]  Op_Sel,
  output logic        Unit_Start,
  input  logic [31:0] Result_In,
  output logic [31:0] Result_Out,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic        Illegal_Op,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       op_sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             start_q;
  logic             illegal_q;
  logic [31:0]      result_q;
  logic             op_illegal;

  // Counter preload is LAT-1 so an op of latency L stays exactly L cycles in EXEC.
  always_comb begin
    cnt_d = CNT_W'(MISC_LAT - 1);
    case (Req_Op)
      4'd0, 4'd1: cnt_d = CNT_W'(ADD_LAT - 1);
      4'd2:       cnt_d = CNT_W'(MUL_LAT - 1);
      4'd3:       cnt_d = CNT_W'(DIV_LAT - 1);
      default:    cnt_d = CNT_W'(MISC_LAT - 1);
    endcase
  end

  assign op_illegal = (Req_Op >= 4'd14);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      op_sel_q  <= 4'd0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_Valid) begin
            op_sel_q <= Req_Op;
            if (op_illegal) begin
              result_q  <= 32'd0;
              illegal_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              cnt_q     <= cnt_d;
              start_q   <= 1'b1;
              illegal_q <= 1'b0;
              state_q   <= EXEC;
            end
          end
        end
        EXEC: begin
          start_q <= 1'b0;
          if (cnt_q == '0) begin
            result_q <= Result_In;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (Rsp_Ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Req_Ready  = (state_q == IDLE);
  assign Rsp_Valid  = (state_q == DONE);
  assign Busy       = (state_q != IDLE);
  assign Op_Sel     = op_sel_q;
  assign Unit_Start = start_q;
  assign Result_Out = result_q;
  assign Illegal_Op = illegal_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized bench for fpu_op_sequencer against a transaction-level latency/result model.
module tb_fpu_op_sequencer;

  localparam int ADD_LAT  = 1;
  localparam int MUL_LAT  = 2;
  localparam int DIV_LAT  = 8;
  localparam int MISC_LAT = 1;
  localparam int CNT_W    = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Req_Valid;
  logic [3:0]  Req_Op;
  logic        Req_Ready;
  logic [3:0]  Op_Sel;
  logic        Unit_Start;
  logic [31:0] Result_In;
  logic [31:0] Result_Out;
  logic        Rsp_Valid;
  logic        Rsp_Ready;
  logic        Illegal_Op;
  logic        Busy;

  int n_checks = 0;
  int n_errors = 0;

  fpu_op_sequencer #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .MISC_LAT(MISC_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_Valid (Req_Valid),
    .Req_Op    (Req_Op),
    .Req_Ready (Req_Ready),
    .Op_Sel    (Op_Sel),
    .Unit_Start(Unit_Start),
    .Result_In (Result_In),
    .Result_Out(Result_Out),
    .Rsp_Valid (Rsp_Valid),
    .Rsp_Ready (Rsp_Ready),
    .Illegal_Op(Illegal_Op),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    if (op <= 4'd1) return ADD_LAT;
    if (op == 4'd2) return MUL_LAT;
    if (op == 4'd3) return DIV_LAT;
    return MISC_LAT;
  endfunction

  // Called and returns at a falling edge with the DUT idle. While busy the request
  // inputs carry junk that must be ignored; stall = DONE cycles with Rsp_Ready low;
  // early = next request already asserted in the release cycle.
  task automatic do_op(input logic [3:0] op, input int stall, input logic early,
                       input logic [3:0] nxt);
    logic [31:0] exp_res;
    logic        ill;
    int          l;
    ill     = (op >= 4'd14);
    l       = lat(op);
    exp_res = 32'd0;
    chk("req_ready_pre", 32'(Req_Ready), 32'd1);
    Req_Valid = 1'b1;
    Req_Op    = op;
    Result_In = $urandom;
    @(posedge CLK);
    @(negedge CLK);
    chk("op_sel_acc", 32'(Op_Sel), 32'(op));
    chk("busy_acc", 32'(Busy), 32'd1);
    if (ill) begin
      chk("start_ill", 32'(Unit_Start), 32'd0);
    end else begin
      for (int k = 1; k <= l; k++) begin
        chk("start_exec", 32'(Unit_Start), (k == 1) ? 32'd1 : 32'd0);
        chk("rsp_valid_exec", 32'(Rsp_Valid), 32'd0);
        chk("op_sel_exec", 32'(Op_Sel), 32'(op));
        chk("busy_exec", 32'(Busy), 32'd1);
        Req_Valid = 1'($urandom_range(0, 1));
        Req_Op    = 4'($urandom);
        Rsp_Ready = 1'($urandom_range(0, 1));
        exp_res   = $urandom;
        Result_In = exp_res;
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid_done", 32'(Rsp_Valid), 32'd1);
      chk("result_done", Result_Out, exp_res);
      chk("illegal_done", 32'(Illegal_Op), 32'(ill));
      chk("op_sel_done", 32'(Op_Sel), 32'(op));
      chk("start_done", 32'(Unit_Start), 32'd0);
      chk("req_ready_done", 32'(Req_Ready), 32'd0);
      Result_In = $urandom;
      if (s < stall) begin
        Rsp_Ready = 1'b0;
        Req_Valid = 1'($urandom_range(0, 1));
        Req_Op    = 4'($urandom);
      end else begin
        Rsp_Ready = 1'b1;
        Req_Valid = early;
        Req_Op    = early ? nxt : 4'($urandom);
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    chk("busy_release", 32'(Busy), 32'd0);
    chk("rsp_valid_release", 32'(Rsp_Valid), 32'd0);
    chk("req_ready_release", 32'(Req_Ready), 32'd1);
    if (!early) Req_Valid = 1'b0;
    Rsp_Ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(Req_Ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(Rsp_Valid), 32'd0);
    chk({tag, "_result"}, Result_Out, 32'd0);
    chk({tag, "_start"}, 32'(Unit_Start), 32'd0);
    chk({tag, "_op_sel"}, 32'(Op_Sel), 32'd0);
    chk({tag, "_illegal"}, 32'(Illegal_Op), 32'd0);
  endtask

  logic [3:0] ops[$];

  initial begin
    RST       = 1'b1;
    Req_Valid = 1'b0;
    Req_Op    = 4'd0;
    Result_In = 32'd0;
    Rsp_Ready = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk_reset_state("rst0");
    RST = 1'b0;

    do_op(4'd0, 0, 1'b0, 4'd0);
    do_op(4'd3, 0, 1'b0, 4'd0);
    do_op(4'd2, 5, 1'b1, 4'd1);
    do_op(4'd1, 0, 1'b0, 4'd0);
    do_op(4'd15, 2, 1'b0, 4'd0);
    do_op(4'd14, 0, 1'b0, 4'd0);
    for (int c = 4; c <= 13; c++) do_op(4'(c), 0, 1'b0, 4'd0);

    // Abort a DIV two cycles into EXEC; no response may follow.
    Req_Valid = 1'b1;
    Req_Op    = 4'd3;
    @(posedge CLK);
    @(negedge CLK);
    Req_Valid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("div_busy_prerst", 32'(Busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST       = 1'b0;
    Rsp_Ready = 1'b1;
    chk_reset_state("rst_div");
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("abort_no_rsp", 32'(Rsp_Valid), 32'd0);
    end

    for (int i = 0; i < 60; i++) ops.push_back(4'($urandom_range(0, 15)));
    for (int i = 0; i < ops.size(); i++) begin
      logic e;
      e = (i + 1 < ops.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_op(ops[i], $urandom_range(0, 3), e, (i + 1 < ops.size()) ? ops[i + 1] : 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
